// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP constants and byte-extraction helpers for the GMII receive path.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
  localparam logic [47:0] ETH_BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [4:0]  ETH_HEAD_LEN  = 5'd14;
  localparam logic [4:0]  ARP_LEN       = 5'd28;
  // Number of 8'h55 bytes preceding the SFD
  localparam logic [4:0]  PREAMBLE_LEN  = 5'd7;

  // Byte idx of a MAC address in wire order (idx 0 = most significant byte)
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [4:0] idx);
    logic [47:0] s;
    s = mac << (8 * idx);
    return s[47:40];
  endfunction

  // Byte idx of an IPv4 address in wire order (idx 0 = most significant byte)
  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [4:0] idx);
    logic [31:0] s;
    s = ip << (8 * idx);
    return s[31:24];
  endfunction

endpackage

// File: rtl/arp_rx.sv
// GMII ARP receive parser: accepts ARP request/reply frames addressed to this board
// and reports the sender MAC/IP and opcode with a one-cycle done pulse.
module arp_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] src_mac,
  output logic [31:0] src_ip
);

  typedef enum logic [4:0] {
    st_idle     = 5'b00001,
    st_preamble = 5'b00010,
    st_eth_head = 5'b00100,
    st_arp_data = 5'b01000,
    st_rx_end   = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic        dv_q;
  logic [7:0]  rxd_q;
  logic [4:0]  cnt_q, cnt_d;
  // Accumulated per-frame mismatch flags
  logic        not_board_q, not_board_d;
  logic        not_bcast_q, not_bcast_d;
  logic        bad_q, bad_d;
  // Shadow copies of the fields being parsed; committed only on acceptance
  logic [47:0] mac_sh_q, mac_sh_d;
  logic [31:0] ip_sh_q, ip_sh_d;
  logic        type_sh_q, type_sh_d;
  logic        done_q, done_d;
  logic        type_q, type_d;
  logic [47:0] src_mac_q, src_mac_d;
  logic [31:0] src_ip_q, src_ip_d;

  assign arp_rx_done = done_q;
  assign arp_rx_type = type_q;
  assign src_mac     = src_mac_q;
  assign src_ip      = src_ip_q;

  // Input capture: all decoding works on this registered copy of the GMII bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q  <= 1'b0;
      rxd_q <= 8'h00;
    end else begin
      dv_q  <= gmii_rx_dv;
      rxd_q <= gmii_rxd;
    end
  end

  // State, counter, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= st_idle;
      cnt_q       <= 5'd0;
      not_board_q <= 1'b0;
      not_bcast_q <= 1'b0;
      bad_q       <= 1'b0;
      mac_sh_q    <= 48'h0;
      ip_sh_q     <= 32'h0;
      type_sh_q   <= 1'b0;
      done_q      <= 1'b0;
      type_q      <= 1'b0;
      src_mac_q   <= 48'h0;
      src_ip_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      not_board_q <= not_board_d;
      not_bcast_q <= not_bcast_d;
      bad_q       <= bad_d;
      mac_sh_q    <= mac_sh_d;
      ip_sh_q     <= ip_sh_d;
      type_sh_q   <= type_sh_d;
      done_q      <= done_d;
      type_q      <= type_d;
      src_mac_q   <= src_mac_d;
      src_ip_q    <= src_ip_d;
    end
  end

  // Next-state logic: frame parsing, field checks and commit of accepted frames
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    not_board_d = not_board_q;
    not_bcast_d = not_bcast_q;
    bad_d       = bad_q;
    mac_sh_d    = mac_sh_q;
    ip_sh_d     = ip_sh_q;
    type_sh_d   = type_sh_q;
    done_d      = 1'b0;
    type_d      = type_q;
    src_mac_d   = src_mac_q;
    src_ip_d    = src_ip_q;

    unique case (state_q)
      st_idle: begin
        cnt_d = 5'd0;
        if (dv_q && rxd_q == ETH_PREAMBLE) begin
          state_d = st_preamble;
        end
      end

      st_preamble: begin
        if (!dv_q) begin
          state_d = st_idle;
          cnt_d   = 5'd0;
        end else if (rxd_q == ETH_PREAMBLE && cnt_q < PREAMBLE_LEN - 5'd1) begin
          cnt_d = cnt_q + 5'd1;
        end else if (rxd_q == ETH_SFD && cnt_q == PREAMBLE_LEN - 5'd1) begin
          state_d     = st_eth_head;
          cnt_d       = 5'd0;
          not_board_d = 1'b0;
          not_bcast_d = 1'b0;
          bad_d       = 1'b0;
        end else begin
          state_d = st_rx_end;
          cnt_d   = 5'd0;
        end
      end

      st_eth_head: begin
        if (!dv_q) begin
          state_d = st_idle;
          cnt_d   = 5'd0;
        end else begin
          // Destination MAC may match either our address or broadcast
          if (cnt_q < 5'd6) begin
            not_board_d = not_board_q | (rxd_q != mac_byte(BOARD_MAC, cnt_q));
            not_bcast_d = not_bcast_q | (rxd_q != mac_byte(ETH_BCAST_MAC, cnt_q));
          end
          if (cnt_q == 5'd12) bad_d = bad_q | (rxd_q != ETH_TYPE_ARP[15:8]);
          if (cnt_q == 5'd13) bad_d = bad_q | (rxd_q != ETH_TYPE_ARP[7:0]);
          if (cnt_q == ETH_HEAD_LEN - 5'd1) begin
            cnt_d = 5'd0;
            if (!(not_board_d && not_bcast_d) && !bad_d) begin
              state_d = st_arp_data;
              bad_d   = 1'b0;
            end else begin
              state_d = st_rx_end;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      st_arp_data: begin
        if (!dv_q) begin
          state_d = st_idle;
          cnt_d   = 5'd0;
        end else begin
          if (cnt_q == 5'd6) begin
            bad_d = bad_q | (rxd_q != ARP_OP_REQ[15:8]);
          end else if (cnt_q == 5'd7) begin
            if (rxd_q == ARP_OP_REQ[7:0])        type_sh_d = 1'b0;
            else if (rxd_q == ARP_OP_REPLY[7:0]) type_sh_d = 1'b1;
            else                                 bad_d     = 1'b1;
          end else if (cnt_q >= 5'd8 && cnt_q <= 5'd13) begin
            mac_sh_d = {mac_sh_q[39:0], rxd_q};
          end else if (cnt_q >= 5'd14 && cnt_q <= 5'd17) begin
            ip_sh_d = {ip_sh_q[23:0], rxd_q};
          end else if (cnt_q >= 5'd24) begin
            bad_d = bad_q | (rxd_q != ip_byte(BOARD_IP, cnt_q - 5'd24));
          end

          if (cnt_q == ARP_LEN - 5'd1) begin
            state_d = st_rx_end;
            cnt_d   = 5'd0;
            if (!bad_d) begin
              done_d    = 1'b1;
              type_d    = type_sh_q;
              src_mac_d = mac_sh_q;
              src_ip_d  = ip_sh_q;
            end
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end

      st_rx_end: begin
        cnt_d = 5'd0;
        if (!dv_q) begin
          state_d = st_idle;
        end
      end

      default: begin
        state_d = st_idle;
        cnt_d   = 5'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_arp_rx.sv
// Testbench for arp_rx: directed and randomized frames, scoreboard-checked done pulses
// and held outputs against a field-level acceptance model.
module tb_arp_rx;

  localparam logic [47:0] BMAC   = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BIP    = 32'hC0A8010A;
  localparam logic [63:0] PRE_OK = 64'h55555555555555D5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gmii_rx_dv;
  logic [7:0]  gmii_rxd;
  logic        arp_rx_done;
  logic        arp_rx_type;
  logic [47:0] src_mac;
  logic [31:0] src_ip;

  arp_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .src_mac     (src_mac),
    .src_ip      (src_ip)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] pre;
    logic [47:0] dmac;
    logic [47:0] emac;
    logic [15:0] etype;
    logic [15:0] op;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
    logic [7:0]  npad;
  } frame_t;

  typedef struct {
    logic        typ;
    logic [47:0] mac;
    logic [31:0] ip;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  logic [7:0]  fb[$];
  logic        exp_typ = 1'b0;
  logic [47:0] exp_mac = 48'h0;
  logic [31:0] exp_ip  = 32'h0;
  int          n_chk  = 0;
  int          n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic put(input logic [63:0] v, input int nbytes);
    for (int i = nbytes - 1; i >= 0; i--) fb.push_back(v[8*i +: 8]);
  endtask

  task automatic build(input frame_t f);
    fb.delete();
    put(f.pre, 8);
    put(64'(f.dmac), 6);
    put(64'(f.emac), 6);
    put(64'(f.etype), 2);
    put(64'h0001_0800_0604, 6);
    put(64'(f.op), 2);
    put(64'(f.sha), 6);
    put(64'(f.spa), 4);
    put(64'(f.tha), 6);
    put(64'(f.tpa), 4);
    for (int i = 0; i < int'(f.npad) + 4; i++) fb.push_back(8'($urandom));
  endtask

  // A frame is accepted when every addressed field is right and all of the
  // 8 preamble + 14 header + 28 ARP bytes arrived before dv dropped.
  function automatic bit accepts(input frame_t f, input int n);
    return (n >= 50) && (f.pre == PRE_OK) &&
           (f.dmac == BMAC || f.dmac == 48'hFFFF_FFFF_FFFF) &&
           (f.etype == 16'h0806) && (f.op == 16'd1 || f.op == 16'd2) &&
           (f.tpa == BIP);
  endfunction

  function automatic frame_t good_frame();
    frame_t f;
    f.pre   = PRE_OK;
    f.dmac  = BMAC;
    f.emac  = 48'({$urandom, $urandom});
    f.etype = 16'h0806;
    f.op    = 16'd1;
    f.sha   = 48'({$urandom, $urandom});
    f.spa   = $urandom;
    f.tha   = 48'h0;
    f.tpa   = BIP;
    f.npad  = 8'd0;
    return f;
  endfunction

  // Drive n bytes of the frame (n<0: whole frame); hold keeps dv high afterwards
  task automatic send(input frame_t f, input int n, input bit hold, input int gap);
    int c0;
    int nn;
    build(f);
    nn = (n < 0 || n > fb.size()) ? fb.size() : n;
    @(posedge clk); #1;
    c0 = cyc;
    if (accepts(f, nn)) begin
      sbq.push_back('{f.op == 16'd2, f.sha, f.spa, c0 + 49 + 2});
      exp_typ = (f.op == 16'd2);
      exp_mac = f.sha;
      exp_ip  = f.spa;
    end
    for (int i = 0; i < nn; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      gmii_rx_dv = 1'b1;
      gmii_rxd   = fb[i];
    end
    if (!hold) begin
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'($urandom);
      end
    end
  endtask

  task automatic held_check(input string tag);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_held_type"}, 64'(arp_rx_type), 64'(exp_typ));
    chk({tag, "_held_mac"}, 64'(src_mac), 64'(exp_mac));
    chk({tag, "_held_ip"}, 64'(src_ip), 64'(exp_ip));
  endtask

  // Monitor: every done pulse must match the oldest outstanding accepted frame
  always @(negedge clk) begin
    if (rst_n && arp_rx_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("done_type", 64'(arp_rx_type), 64'(e.typ));
        chk("done_mac", 64'(src_mac), 64'(e.mac));
        chk("done_ip", 64'(src_ip), 64'(e.ip));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    int     r;
    int     n;
    rst_n      = 1'b0;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_done", 64'(arp_rx_done), 64'(0));
    chk("reset_type", 64'(arp_rx_type), 64'(0));
    chk("reset_mac", 64'(src_mac), 64'(0));
    chk("reset_ip", 64'(src_ip), 64'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Broadcast request from 00AABBCCDDEE / 192.168.1.102
    f = good_frame();
    f.dmac = 48'hFFFF_FFFF_FFFF;
    f.sha  = 48'h00AA_BBCC_DDEE;
    f.spa  = 32'hC0A80166;
    send(f, -1, 1'b0, 1); held_check("bcast_req");

    // Unicast reply with padding and FCS
    f = good_frame();
    f.op = 16'd2; f.npad = 8'd18;
    send(f, -1, 1'b0, 1); held_check("ucast_reply");

    f = good_frame(); f.tpa = 32'hC0A8010B;
    send(f, -1, 1'b0, 1); held_check("bad_tip");
    f = good_frame(); f.dmac = 48'h00_11_22_33_44_56;
    send(f, -1, 1'b0, 1); held_check("bad_dmac");
    f = good_frame(); f.etype = 16'h0800;
    send(f, -1, 1'b0, 1); held_check("bad_etype");

    f = good_frame(); f.pre[8*4 +: 8] = 8'h54;
    send(f, -1, 1'b0, 1); held_check("bad_pre");
    f = good_frame(); f.op = 16'd2;
    send(f, -1, 1'b0, 1); held_check("after_bad_pre");

    // dv dropped at ARP byte 15, then an immediate valid frame
    f = good_frame();
    send(f, 8 + 14 + 15, 1'b0, 1);
    f = good_frame();
    send(f, -1, 1'b0, 1); held_check("after_trunc");

    // Reset pulsed while eth header byte 5 is on the wire
    f = good_frame();
    send(f, 8 + 6, 1'b1, 0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    exp_typ = 1'b0; exp_mac = 48'h0; exp_ip = 32'h0;
    chk("midrst_done", 64'(arp_rx_done), 64'(0));
    chk("midrst_type", 64'(arp_rx_type), 64'(0));
    chk("midrst_mac", 64'(src_mac), 64'(0));
    chk("midrst_ip", 64'(src_ip), 64'(0));
    @(posedge clk); #1;
    gmii_rx_dv = 1'b0;
    rst_n = 1'b1;
    f = good_frame();
    send(f, -1, 1'b0, 1); held_check("after_rst");

    // Randomized frames
    for (int k = 0; k < 40; k++) begin
      f = good_frame();
      case ($urandom_range(0, 3))
        0: f.dmac = BMAC;
        1: f.dmac = 48'hFFFF_FFFF_FFFF;
        2: f.dmac = BMAC ^ (48'h1 << $urandom_range(0, 47));
        default: f.dmac = BMAC;
      endcase
      r = $urandom_range(0, 99);
      if (r < 8) f.etype = 16'h0800;
      else if (r < 12) f.etype = 16'($urandom);
      case ($urandom_range(0, 7))
        0, 2: f.op = 16'd1;
        1, 3: f.op = 16'd2;
        4: f.op = 16'd0;
        5: f.op = 16'd3;
        6: f.op = 16'h0101;
        default: f.op = 16'($urandom);
      endcase
      if ($urandom_range(0, 99) < 20) f.tpa = BIP ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 99) < 10) begin
        r = $urandom_range(1, 7);
        f.pre[8*(7-r) +: 8] = f.pre[8*(7-r) +: 8] ^ 8'(1 << $urandom_range(0, 7));
      end
      f.npad = 8'($urandom_range(0, 20));
      n = ($urandom_range(0, 99) < 10) ? $urandom_range(1, 55) : -1;
      send(f, n, 1'b0, $urandom_range(1, 3));
      held_check("rand");
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pending_done", 64'(sbq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
